mixador_pwm: RTL and testbench

Downstream stage of the per-voice instrumento array. Takes the N voice samples and the key vector, and averages the samples of the active voices. It drives the result as a single-bit PWM audio output for the board pin. It also exposes the mixed sample and a valid strobe for monitoring or later DAC stages.

---
 rtl/mixador_pkg.sv | 32 +++
 rtl/mixador_pwm_divisor.sv | 103 ++++++++++
 rtl/mixador_pwm.sv | 183 ++++++++++++++++++
 tb/tb_mixador_pwm.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mixador_pkg.sv
// mixador_pkg -- definitions shared by the mixer slice.
//   N_VOZES_PADRAO / LARG_PADRAO : default voice count and sample width. The
//                                  key-mapping and instrument blocks use the
//                                  same defaults.
//   estado_t                     : mixer FSM states.
//   clog2                        : ceil(log2(v)) for sizing at elaboration.
package mixador_pkg;

  localparam int N_VOZES_PADRAO = 10;
  localparam int LARG_PADRAO    = 8;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    SOMA   = 2'd1,
    DIVIDE = 2'd2,
    FIM    = 2'd3
  } estado_t;

  // Returns ceil(log2(valor)). Values 0 and 1 both give 0.
  function automatic int clog2(input int valor);
    int r;
    int v;
    r = 0;
    v = valor - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mixador_pwm_divisor.sv
// divisor_seq -- sequential restoring unsigned divider.
//   clk, rst           : clock and asynchronous active-high reset
//   start              : one-cycle request. Operands are sampled on this edge.
//   dividendo, divisor : DW-bit unsigned operands
//   quociente          : truncated quotient. It holds until the next start.
//   pronto             : one-cycle pulse when quociente is valid
// The start edge already retires the first quotient bit, so the result is
// ready DW edges after start (start edge included). A zero divisor gives a
// quotient of 0, and pronto is raised right after the start edge.
module divisor_seq
  import mixador_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividendo,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quociente,
  output logic          pronto
);

  localparam int CW = clog2(DW + 1);

  logic [DW-1:0] r_resto;
  logic [DW-1:0] r_quoc;
  logic [CW-1:0] r_passos;
  logic          r_ocupado;
  logic          r_pronto;

  logic [DW-1:0] w_resto_in;
  logic [DW-1:0] w_quoc_in;
  logic [DW:0]   w_desloc;
  logic [DW:0]   w_teste;
  logic [DW-1:0] w_resto_novo;
  logic [DW-1:0] w_quoc_novo;

  // One restoring step. On start it runs from a cleared remainder and the
  // fresh dividend.
  always_comb begin
    if (start) begin
      w_resto_in = {DW{1'b0}};
      w_quoc_in  = dividendo;
    end else begin
      w_resto_in = r_resto;
      w_quoc_in  = r_quoc;
    end
    w_desloc = {w_resto_in, w_quoc_in[DW-1]};
    w_teste  = w_desloc - {1'b0, divisor};
    // A set bit DW means the trial subtraction went negative, so the
    // remainder is restored.
    if (w_teste[DW]) begin
      w_resto_novo = w_desloc[DW-1:0];
      w_quoc_novo  = {w_quoc_in[DW-2:0], 1'b0};
    end else begin
      w_resto_novo = w_teste[DW-1:0];
      w_quoc_novo  = {w_quoc_in[DW-2:0], 1'b1};
    end
  end

  // Division state: operand load, iteration, and the ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resto   <= {DW{1'b0}};
      r_quoc    <= {DW{1'b0}};
      r_passos  <= {CW{1'b0}};
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else if (start) begin
      if (divisor == {DW{1'b0}}) begin
        r_resto   <= {DW{1'b0}};
        r_quoc    <= {DW{1'b0}};
        r_passos  <= {CW{1'b0}};
        r_ocupado <= 1'b0;
        r_pronto  <= 1'b1;
      end else begin
        r_resto   <= w_resto_novo;
        r_quoc    <= w_quoc_novo;
        r_passos  <= CW'(DW - 1);
        r_ocupado <= (DW > 1);
        r_pronto  <= (DW == 1);
      end
    end else if (r_ocupado) begin
      r_resto  <= w_resto_novo;
      r_quoc   <= w_quoc_novo;
      r_passos <= r_passos - CW'(1);
      if (r_passos == CW'(1)) begin
        r_ocupado <= 1'b0;
        r_pronto  <= 1'b1;
      end else begin
        r_ocupado <= 1'b1;
        r_pronto  <= 1'b0;
      end
    end else begin
      r_pronto <= 1'b0;
    end
  end

  assign quociente = r_quoc;
  assign pronto    = r_pronto;

endmodule

// File: rtl/mixador_pwm.sv
// mixador_pwm -- averages the active voice samples once per PWM period and
// plays the result on a single-bit PWM pin.
//   clk, rst       : clock and asynchronous active-high reset
//   teclas         : key vector. Bit i set means voice i is active.
//   saida          : per-voice unsigned samples
//   amostra        : last completed mixed sample
//   amostra_valida : one-cycle pulse when amostra updates
//   pwm_out        : registered PWM output. duty = amostra of the previous period.
module mixador_pwm
  import mixador_pkg::*;
#(
  parameter int N_VOZES  = N_VOZES_PADRAO,
  parameter int LARG     = LARG_PADRAO,
  parameter int PWM_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_VOZES-1:0]             teclas,
  input  logic [N_VOZES-1:0][LARG-1:0]   saida,
  output logic [LARG-1:0]                amostra,
  output logic                           amostra_valida,
  output logic                           pwm_out
);

  localparam int SOMA_W = LARG + clog2(N_VOZES);
  localparam int IDX_W  = (clog2(N_VOZES) > 0) ? clog2(N_VOZES) : 1;
  localparam int ATV_W  = clog2(N_VOZES + 1);
  localparam int CMP_W  = (LARG > PWM_BITS) ? LARG : PWM_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};
  localparam logic [IDX_W-1:0]    IDX_ULT = IDX_W'(N_VOZES - 1);

  // The whole sum/divide sequence must finish inside one PWM period.
  // Otherwise a boundary could arrive while the mixer is still busy.
  generate
    if (!(N_VOZES + SOMA_W + 4 < 2**PWM_BITS)) begin : g_periodo_curto
      $error("mixador_pwm: PWM period too short for N_VOZES/LARG");
    end
  endgenerate

  estado_t                      r_estado;
  estado_t                      w_estado_next;
  logic [PWM_BITS-1:0]          r_cnt;
  logic [PWM_BITS-1:0]          w_cnt_next;
  logic [LARG-1:0]              r_duty;
  logic [LARG-1:0]              w_duty_next;
  logic                         r_pwm;
  logic                         w_fronteira;
  logic [N_VOZES-1:0]           r_teclas;
  logic [N_VOZES-1:0][LARG-1:0] r_saida;
  logic [IDX_W-1:0]             r_idx;
  logic [SOMA_W-1:0]            r_soma;
  logic [ATV_W-1:0]             r_ativos;
  logic                         r_div_start;
  logic                         w_div_start;
  logic [SOMA_W-1:0]            w_quoc;
  logic                         w_div_pronto;
  logic [LARG-1:0]              w_quoc_sat;
  logic [LARG-1:0]              r_amostra;
  logic                         r_valida;

  assign w_cnt_next  = r_cnt + PWM_BITS'(1);
  assign w_fronteira = (r_cnt == CNT_MAX);
  // The new duty is used for the cnt=0 output of the next period.
  assign w_duty_next = w_fronteira ? r_amostra : r_duty;
  // A zero voice count skips the divider.
  assign w_div_start = r_div_start && (r_ativos != ATV_W'(0));
  // The mean never exceeds a voice sample. Clamp anyway so that a corrupted
  // quotient cannot wrap to a small value.
  assign w_quoc_sat  = (|w_quoc[SOMA_W-1:LARG]) ? {LARG{1'b1}} : w_quoc[LARG-1:0];

  divisor_seq #(
    .DW(SOMA_W)
  ) u_divisor (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividendo (r_soma),
    .divisor   (SOMA_W'(r_ativos)),
    .quociente (w_quoc),
    .pronto    (w_div_pronto)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_estado_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_estado_next = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (w_fronteira) begin
          w_estado_next = SOMA;
        end else begin
          w_estado_next = OCIOSO;
        end
      end
      SOMA: begin
        if (r_idx == IDX_ULT) begin
          w_estado_next = DIVIDE;
        end else begin
          w_estado_next = SOMA;
        end
      end
      DIVIDE: begin
        if ((r_ativos == ATV_W'(0)) || w_div_pronto) begin
          w_estado_next = FIM;
        end else begin
          w_estado_next = DIVIDE;
        end
      end
      FIM: begin
        w_estado_next = OCIOSO;
      end
      default: begin
        w_estado_next = OCIOSO;
      end
    endcase
  end

  // PWM counter/output and the mixing datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= {PWM_BITS{1'b0}};
      r_duty      <= {LARG{1'b0}};
      r_pwm       <= 1'b0;
      r_teclas    <= {N_VOZES{1'b0}};
      r_saida     <= '0;
      r_idx       <= {IDX_W{1'b0}};
      r_soma      <= {SOMA_W{1'b0}};
      r_ativos    <= {ATV_W{1'b0}};
      r_div_start <= 1'b0;
      r_amostra   <= {LARG{1'b0}};
      r_valida    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_duty   <= w_duty_next;
      r_pwm    <= (CMP_W'(w_cnt_next) < CMP_W'(w_duty_next));
      r_valida <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          r_div_start <= 1'b0;
          if (w_fronteira) begin
            r_teclas <= teclas;
            r_saida  <= saida;
            r_idx    <= {IDX_W{1'b0}};
          end
        end
        SOMA: begin
          if (r_teclas[r_idx]) begin
            r_soma   <= r_soma + SOMA_W'(r_saida[r_idx]);
            r_ativos <= r_ativos + ATV_W'(1);
          end
          r_idx       <= r_idx + IDX_W'(1);
          r_div_start <= (r_idx == IDX_ULT);
        end
        DIVIDE: begin
          r_div_start <= 1'b0;
        end
        FIM: begin
          r_div_start <= 1'b0;
          r_amostra   <= (r_ativos == ATV_W'(0)) ? {LARG{1'b0}} : w_quoc_sat;
          r_valida    <= 1'b1;
          r_soma      <= {SOMA_W{1'b0}};
          r_ativos    <= {ATV_W{1'b0}};
        end
        default: begin
          r_div_start <= 1'b0;
        end
      endcase
    end
  end

  assign amostra        = r_amostra;
  assign amostra_valida = r_valida;
  assign pwm_out        = r_pwm;

endmodule

// File: tb/tb_mixador_pwm.sv
// tb_mixador_pwm -- directed self-checking bench for mixador_pwm.
// Cycle arithmetic below counts edges from a period boundary B, which is the
// edge where cnt==255 is sampled. A valid pulse is seen after B+24, and the
// next boundary is B+256.
module tb_mixador_pwm;

  logic            clk;
  logic            rst;
  logic [9:0]      teclas;
  logic [9:0][7:0] saida;
  logic [7:0]      amostra;
  logic            amostra_valida;
  logic            pwm_out;

  int n_assert;
  int n_fail;
  int ciclos;
  int altos;

  mixador_pwm #(
    .N_VOZES  (10),
    .LARG     (8),
    .PWM_BITS (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .teclas         (teclas),
    .saida          (saida),
    .amostra        (amostra),
    .amostra_valida (amostra_valida),
    .pwm_out        (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [9:0] t, input logic [7:0] v);
    teclas = t;
    for (int i = 0; i < 10; i++) saida[i] = v;
  endtask

  // Counts negedges up to and including the first one that shows a valid pulse.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (amostra_valida !== 1'b1 && n < 700);
    if (amostra_valida !== 1'b1) check({tag, "_timeout"}, {31'd0, amostra_valida}, 32'd1);
  endtask

  // Skips 'skip' negedges, then samples pwm_out on 256 consecutive negedges.
  task automatic count_pwm(input int skip, output int h);
    repeat (skip) @(negedge clk);
    h = 0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      if (pwm_out === 1'b1) h++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_all(10'h3FF, 8'd200);
    repeat (3) @(negedge clk);
    check("rst_amostra", {24'd0, amostra}, 32'd0);
    check("rst_valida", {31'd0, amostra_valida}, 32'd0);
    check("rst_pwm", {31'd0, pwm_out}, 32'd0);

    // Test 1: all keys active, all samples 200. First boundary is edge 256
    // after release, so valid appears at edge 280.
    rst = 1'b0;
    wait_valid("t1", ciclos);
    check("t1_latency", ciclos, 32'd280);
    check("t1_amostra", {24'd0, amostra}, 32'd200);
    @(negedge clk);
    check("t1_pulse_width", {31'd0, amostra_valida}, 32'd0);
    count_pwm(231, altos);
    check("t1_pwm_high", altos, 32'd200);

    // Test 2: only voice 3 active (100). The others hold 255 and must be ignored.
    // We are at B+255. The next snapshot is one edge later and valid follows 24 after that.
    set_all(10'b00_0000_1000, 8'd255);
    saida[3] = 8'd100;
    wait_valid("t2", ciclos);
    check("t2_latency", ciclos, 32'd25);
    check("t2_amostra", {24'd0, amostra}, 32'd100);

    // Test 3: voices 0,1 -> (10+11)/2 truncated = 10.
    set_all(10'b00_0000_0011, 8'd99);
    saida[0] = 8'd10;
    saida[1] = 8'd11;
    wait_valid("t3", ciclos);
    check("t3_period", ciclos, 32'd256);
    check("t3_amostra", {24'd0, amostra}, 32'd10);

    // Test 4: no keys -> 0, and PWM stays low for the period that plays it.
    // The zero-voice path finishes at B+12, so the next boundary is 244 edges away.
    set_all(10'b00_0000_0000, 8'd77);
    wait_valid("t4", ciclos);
    check("t4_amostra", {24'd0, amostra}, 32'd0);
    count_pwm(244, altos);
    check("t4_pwm_high", altos, 32'd0);

    // Test 5: full scale -> 255, and PWM is high 255 of 256 clocks.
    set_all(10'h3FF, 8'd255);
    wait_valid("t5", ciclos);
    check("t5_latency", ciclos, 32'd25);
    check("t5_amostra", {24'd0, amostra}, 32'd255);
    count_pwm(232, altos);
    check("t5_pwm_high", altos, 32'd255);

    // Test 6a: change the samples during SOMA (edge B+260). The result must
    // still reflect the snapshot.
    set_all(10'h3FF, 8'd50);
    wait_valid("t6_pre", ciclos);
    check("t6_pre_amostra", {24'd0, amostra}, 32'd50);
    repeat (236) @(negedge clk);
    set_all(10'h3FF, 8'd150);
    wait_valid("t6_snap", ciclos);
    check("t6_snap_latency", ciclos, 32'd20);
    check("t6_snap_amostra", {24'd0, amostra}, 32'd50);
    wait_valid("t6_new", ciclos);
    check("t6_new_period", ciclos, 32'd256);
    check("t6_new_amostra", {24'd0, amostra}, 32'd150);

    // Test 6b: reset at B+270, while the divider is running. The outputs
    // clear at once (pwm_out was high because cnt=14 < 150).
    repeat (246) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_amostra", {24'd0, amostra}, 32'd0);
    check("t6_rst_valida", {31'd0, amostra_valida}, 32'd0);
    check("t6_rst_pwm", {31'd0, pwm_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid("t6_after", ciclos);
    check("t6_after_latency", ciclos, 32'd280);
    check("t6_after_amostra", {24'd0, amostra}, 32'd150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
